// File: rtl/rr_mux_arbiter_pkg.sv
// Shared parameters and types for the round-robin mux arbiter.
package rr_mux_pkg;
    localparam int NR_REQ   = 4;
    localparam int DATA_LEN = 2;
    localparam int SEL_LEN  = $clog2(NR_REQ);

    typedef logic [SEL_LEN-1:0]  sel_t;
    typedef logic [DATA_LEN-1:0] data_t;
    typedef enum logic {IDLE, FULL} state_t;
endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester-side and consumer-side handshake bundle of the arbiter.
interface rr_mux_arbiter_if;
    import rr_mux_pkg::*;

    logic [NR_REQ-1:0] req_valid;
    data_t             req_data [NR_REQ-1:0];
    logic [NR_REQ-1:0] req_ready;
    logic              out_valid;
    logic              out_ready;
    data_t             out_data;
    sel_t              out_sel;

    // Environment side: drives requests and consumer back-pressure.
    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_sel
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/rr_mux_arbiter_mux.sv
// Generic key/value mux: returns the data paired with a matching key, else default_out.
// Each lut entry is {key, data}, entry i at bits [i*(KEY_LEN+DATA_LEN) +: KEY_LEN+DATA_LEN].
module MuxKeyWithDefault #(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
) (
    output logic [DATA_LEN-1:0]                  out,
    input  logic [KEY_LEN-1:0]                   key,
    input  logic [DATA_LEN-1:0]                  default_out,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut
);
    localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

    // Keys are expected unique, so at most one entry matches.
    always_comb begin
        out = default_out;
        for (int i = 0; i < NR_KEY; i++) begin
            if (lut[i*PAIR_LEN+DATA_LEN +: KEY_LEN] == key)
                out = lut[i*PAIR_LEN +: DATA_LEN];
        end
    end
endmodule

// File: rtl/rr_mux_arbiter_pick.sv
// Round-robin winner selection: rotate requests so ptr sits at bit 0,
// take the lowest set bit, then add ptr back (wraps in SEL_LEN bits).
module rr_pick
    import rr_mux_pkg::*;
(
    input  logic [NR_REQ-1:0] req_valid,
    input  sel_t              ptr,
    output logic              any,
    output sel_t              winner
);
    logic [NR_REQ-1:0] rotated;
    sel_t              offset;

    // Rotate right by ptr; sel_t arithmetic provides the modulo.
    always_comb begin
        rotated = '0;
        for (int k = 0; k < NR_REQ; k++)
            rotated[k] = req_valid[sel_t'(sel_t'(k) + ptr)];
    end

    // Lowest set bit of the rotated vector is the nearest requester after ptr.
    always_comb begin
        offset = '0;
        for (int k = NR_REQ-1; k >= 0; k--) begin
            if (rotated[k])
                offset = sel_t'(k);
        end
    end

    assign any    = |req_valid;
    assign winner = sel_t'(offset + ptr);
endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one registered output word between NR_REQ requesters.
//
//   state | meaning
//   IDLE  | output register empty, out_valid=0
//   FULL  | output register holds a word, out_valid=1
module rr_mux_arbiter
    import rr_mux_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    rr_mux_arbiter_if.slave bus
);
    localparam int PAIR_LEN = SEL_LEN + DATA_LEN;

    state_t                     state;
    sel_t                       ptr;
    sel_t                       winner;
    logic                       any;
    logic                       can_load;
    logic                       accept;
    data_t                      mux_out;
    logic [NR_REQ*PAIR_LEN-1:0] lut;

    rr_pick u_pick (
        .req_valid (bus.req_valid),
        .ptr       (ptr),
        .any       (any),
        .winner    (winner)
    );

    for (genvar i = 0; i < NR_REQ; i++) begin : g_lut
        assign lut[i*PAIR_LEN +: PAIR_LEN] = {sel_t'(i), bus.req_data[i]};
    end

    MuxKeyWithDefault #(
        .NR_KEY   (NR_REQ),
        .KEY_LEN  (SEL_LEN),
        .DATA_LEN (DATA_LEN)
    ) u_mux (
        .out         (mux_out),
        .key         (winner),
        .default_out ('0),
        .lut         (lut)
    );

    // A new word may enter when the register is empty or drains this cycle.
    assign can_load = !bus.out_valid || bus.out_ready;
    assign accept   = can_load && any && !rst;

    // One-hot grant to the winner, only when the word is actually taken.
    always_comb begin
        bus.req_ready = '0;
        if (accept)
            bus.req_ready[winner] = 1'b1;
    end

    // Output register, pointer and state; pointer moves only on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sel   <= '0;
            ptr           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state         <= FULL;
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= mux_out;
                        bus.out_sel   <= winner;
                        ptr           <= sel_t'(winner + 1'b1);
                    end
                end
                FULL: begin
                    if (bus.out_ready) begin
                        if (accept) begin
                            bus.out_data <= mux_out;
                            bus.out_sel  <= winner;
                            ptr          <= sel_t'(winner + 1'b1);
                        end else begin
                            state         <= IDLE;
                            bus.out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench: reference model predicts grants and pushes expected
// output words; an independent monitor pops them when the consumer takes a word.
module tb_rr_mux_arbiter;
    import rr_mux_pkg::*;

    typedef struct {
        int sel;
        int data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rr_mux_arbiter_if bus();

    rr_mux_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];
    int   m_ptr    = 0;
    bit   m_full   = 0;
    bit   held     = 0;
    int   last_sel;
    int   last_data;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // First valid requester at or after p, scanning circularly; -1 if none.
    function automatic int pick(input logic [NR_REQ-1:0] v, input int p);
        for (int k = 0; k < NR_REQ; k++) begin
            int idx;
            idx = (p + k) % NR_REQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Reference model, evaluated mid-cycle with inputs stable.
    always @(negedge clk) begin
        if (rst) begin
            check("ready_in_reset", int'(bus.req_ready), 0);
            q.delete();
            m_ptr  = 0;
            m_full = 0;
        end else begin
            int          w;
            bit          acc;
            logic [3:0]  er;
            check("out_valid", int'(bus.out_valid), int'(m_full));
            w   = pick(bus.req_valid, m_ptr);
            acc = (!m_full || bus.out_ready) && (w >= 0);
            er  = '0;
            if (acc) er[w] = 1'b1;
            check("req_ready", int'(bus.req_ready), int'(er));
            if (acc) begin
                q.push_back('{sel: w, data: int'(bus.req_data[w])});
                m_ptr  = (w + 1) % NR_REQ;
                m_full = 1;
            end else if (bus.out_ready) begin
                m_full = 0;
            end
        end
    end

    // Monitor: word stability under stall, scoreboard compare on transfer.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (held) begin
                check("hold_sel", int'(bus.out_sel), last_sel);
                check("hold_data", int'(bus.out_data), last_data);
            end
            if (bus.out_ready) begin
                held = 0;
                if (q.size() == 0) begin
                    check("sb_unexpected_word", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("sb_sel", int'(bus.out_sel), e.sel);
                    check("sb_data", int'(bus.out_data), e.data);
                end
            end else begin
                held      = 1;
                last_sel  = int'(bus.out_sel);
                last_data = int'(bus.out_data);
            end
        end else begin
            held = 0;
        end
    end

    // Apply inputs, run through one rising edge, return 1 time unit after it.
    task automatic cycle(input logic [NR_REQ-1:0] v, input logic rdy, input logic r);
        bus.req_valid = v;
        bus.out_ready = rdy;
        rst           = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < NR_REQ; i++) bus.req_data[i] = data_t'($urandom);

        // Reset with idle requesters.
        repeat (5) cycle(4'b0000, 1'b1, 1'b1);
        check("t1_out_valid", int'(bus.out_valid), 0);
        check("t1_out_sel", int'(bus.out_sel), 0);

        // Single request from index 2 out of idle.
        cycle(4'b0000, 1'b1, 1'b0);
        bus.req_data[2] = 2'b11;
        cycle(4'b0100, 1'b1, 1'b0);
        check("t2_out_valid", int'(bus.out_valid), 1);
        check("t2_out_data", int'(bus.out_data), 3);
        check("t2_out_sel", int'(bus.out_sel), 2);
        cycle(4'b1111, 1'b1, 1'b0);
        check("t2_ptr_after", int'(bus.out_sel), 3);
        cycle(4'b0000, 1'b1, 1'b0);

        // All valid from reset: rotating grants, no bubbles.
        cycle(4'b0000, 1'b1, 1'b1);
        for (int i = 0; i < NR_REQ; i++) bus.req_data[i] = data_t'(i);
        for (int k = 0; k < 8; k++) begin
            cycle(4'b1111, 1'b1, 1'b0);
            check("t3_out_valid", int'(bus.out_valid), 1);
            check("t3_out_sel", int'(bus.out_sel), k % NR_REQ);
            check("t3_out_data", int'(bus.out_data), k % NR_REQ);
        end

        // Stall while holding index 1, then release.
        cycle(4'b0000, 1'b1, 1'b1);
        cycle(4'b0010, 1'b1, 1'b0);
        repeat (3) cycle(4'b1111, 1'b0, 1'b0);
        check("t4_hold_sel", int'(bus.out_sel), 1);
        check("t4_hold_valid", int'(bus.out_valid), 1);
        cycle(4'b1111, 1'b1, 1'b0);
        check("t4_next_grant", int'(bus.out_sel), 2);

        // Pointer wrap from 3 back to 0.
        cycle(4'b0000, 1'b1, 1'b1);
        cycle(4'b0100, 1'b1, 1'b0);
        cycle(4'b1001, 1'b1, 1'b0);
        check("t5_grant3", int'(bus.out_sel), 3);
        cycle(4'b1001, 1'b1, 1'b0);
        check("t5_wrap0", int'(bus.out_sel), 0);

        // Reset while a word is stalled.
        cycle(4'b1111, 1'b1, 1'b0);
        cycle(4'b1111, 1'b0, 1'b1);
        check("t6_valid_cleared", int'(bus.out_valid), 0);
        check("t6_sel_cleared", int'(bus.out_sel), 0);
        cycle(4'b1010, 1'b1, 1'b0);
        check("t6_first_grant", int'(bus.out_sel), 1);

        // Randomized traffic with back-pressure and occasional reset.
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < NR_REQ; i++) bus.req_data[i] = data_t'($urandom);
            cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 99) == 0));
        end

        repeat (3) cycle(4'b0000, 1'b1, 1'b0);
        check("sb_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
